rx_frontend_iqcal: RTL and testbench

Parametrised next-generation RX front end. Takes two raw ADC channels and applies optional I/Q swap, Q inversion and real-only mode. Then applies per-channel DC offset removal (fixed or auto-tracking), magnitude/phase I/Q imbalance correction and saturating output. Sits between the ADC capture registers and the DDC chain. Single clock domain, with a fixed-latency pipeline, an output strobe and a saturating ADC-overflow counter.

---
 rtl/rx_frontend_iqcal.sv | 249 ++++++++++++++++++++++++
 tb/tb_rx_frontend_iqcal.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frontend_iqcal.sv
// rx_frontend_iqcal: ADC capture to DDC front end.
// Channel select/swap/invert/real-only, per-channel DC removal (fixed or
// auto-tracking), optional I/Q imbalance correction, saturating outputs,
// four-stage fixed-latency pipeline and a saturating ADC overflow counter.
// Optional macro: RX_IQCOMP_EN enables the magnitude/phase correction
// multipliers; without it stages 3 and 4 are plain delay registers.
module rx_frontend_iqcal #(
  parameter int unsigned BASE       = 0,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned CORR_WIDTH = 18,
  parameter int unsigned DC_SHIFT   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic [IN_WIDTH-1:0]  adc_a,
  input  logic                 adc_ovf_a,
  input  logic [IN_WIDTH-1:0]  adc_b,
  input  logic                 adc_ovf_b,
  input  logic                 run,
  output logic [OUT_WIDTH-1:0] i_out,
  output logic [OUT_WIDTH-1:0] q_out,
  output logic                 strobe_out,
  output logic [15:0]          ovf_count
);

  localparam int unsigned OW  = OUT_WIDTH;
  localparam int unsigned IW  = IN_WIDTH;
  localparam int unsigned CW  = CORR_WIDTH;
  localparam int unsigned SW  = OUT_WIDTH + 2;
  localparam int unsigned AW  = OUT_WIDTH + DC_SHIFT;
  localparam int unsigned PAD = OUT_WIDTH - IN_WIDTH;

  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};
  localparam logic [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};

  // Clamp a wide signed value into the output range.
  function automatic logic [OW-1:0] sat_out(input logic [SW-1:0] v);
    logic [SW-OW:0] top;
    top = v[SW-1:OW-1];
    if ((&top) || !(|top)) sat_out = v[OW-1:0];
    else                   sat_out = v[SW-1] ? MINV : MAXV;
  endfunction

  // Clamp the integrator sum into the accumulator range.
  function automatic logic [AW-1:0] sat_acc(input logic [AW:0] v);
    if (v[AW] == v[AW-1]) sat_acc = v[AW-1:0];
    else                  sat_acc = v[AW] ? AMIN : AMAX;
  endfunction

  // Setting bus decode
  logic w_wr_cfg, w_wr_dci, w_wr_dcq, w_wr_clr;
  assign w_wr_cfg = set_stb && (set_addr == 8'(BASE + 0));
  assign w_wr_dci = set_stb && (set_addr == 8'(BASE + 3));
  assign w_wr_dcq = set_stb && (set_addr == 8'(BASE + 4));
  assign w_wr_clr = set_stb && (set_addr == 8'(BASE + 5));

  logic w_unused;
  assign w_unused = ^{set_data[30:OW], 1'(CW)};

  logic r_swap, r_inv_q, r_real;

  // Configuration register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swap  <= 1'b0;
      r_inv_q <= 1'b0;
      r_real  <= 1'b0;
    end else if (w_wr_cfg) begin
      r_swap  <= set_data[0];
      r_inv_q <= set_data[1];
      r_real  <= set_data[2];
    end
  end

  // S1: channel select, left-align, optional Q inversion / real-only
  logic [OW-1:0] w_a_al, w_b_al, w_i_sel, w_q_sel, w_q_inv, w_q_s1;
  assign w_a_al  = {adc_a, {PAD{1'b0}}};
  assign w_b_al  = {adc_b, {PAD{1'b0}}};
  assign w_i_sel = r_swap ? w_b_al : w_a_al;
  assign w_q_sel = r_swap ? w_a_al : w_b_al;
  assign w_q_inv = (w_q_sel == MINV) ? MAXV : -w_q_sel;
  assign w_q_s1  = r_real ? '0 : (r_inv_q ? w_q_inv : w_q_sel);

  logic signed [OW-1:0] r_i1, r_q1;

  // S1 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1 <= '0;
      r_q1 <= '0;
    end else begin
      r_i1 <= w_i_sel;
      r_q1 <= w_q_s1;
    end
  end

  // S2: DC offset removal; offset is the top of each integrator
  logic signed [AW-1:0] r_acc_i, r_acc_q;
  logic                 r_auto_i, r_auto_q;
  logic signed [OW-1:0] w_ofs_i, w_ofs_q;
  logic signed [SW-1:0] w_i_diff, w_q_diff;
  logic signed [OW-1:0] r_i2, r_q2;

  assign w_ofs_i  = r_acc_i[AW-1 -: OW];
  assign w_ofs_q  = r_acc_q[AW-1 -: OW];
  assign w_i_diff = SW'(r_i1) - SW'(w_ofs_i);
  assign w_q_diff = SW'(r_q1) - SW'(w_ofs_q);

  // S2 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i2 <= '0;
      r_q2 <= '0;
    end else begin
      r_i2 <= sat_out(w_i_diff);
      r_q2 <= sat_out(w_q_diff);
    end
  end

  // Auto-DC integrators; a bus write overrides a same-cycle update
  logic signed [AW:0] w_acc_i_sum, w_acc_q_sum;
  assign w_acc_i_sum = (AW+1)'(r_acc_i) + (AW+1)'(r_i2);
  assign w_acc_q_sum = (AW+1)'(r_acc_q) + (AW+1)'(r_q2);

  // DC offset integrators and auto-enable flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_auto_i <= 1'b0;
      r_auto_q <= 1'b0;
    end else begin
      if (w_wr_dci) begin
        r_acc_i  <= {set_data[OW-1:0], {DC_SHIFT{1'b0}}};
        r_auto_i <= set_data[31];
      end else if (r_auto_i && run) begin
        r_acc_i  <= sat_acc(w_acc_i_sum);
      end
      if (w_wr_dcq) begin
        r_acc_q  <= {set_data[OW-1:0], {DC_SHIFT{1'b0}}};
        r_auto_q <= set_data[31];
      end else if (r_auto_q && run) begin
        r_acc_q  <= sat_acc(w_acc_q_sum);
      end
    end
  end

  logic signed [OW-1:0] r_i3, r_q3;

`ifdef RX_IQCOMP_EN
  logic signed [CW-1:0]   r_mag, r_phase;
  logic signed [CW-1:0]   w_i_top;
  logic signed [2*CW-1:0] r_pm, r_pp;
  logic signed [2*CW-1:0] w_pm_sh, w_pp_sh;
  logic signed [SW-1:0]   w_term_i, w_term_q, w_i_sum, w_q_sum;

  // Correction coefficient registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_phase <= '0;
    end else begin
      if (set_stb && (set_addr == 8'(BASE + 1))) r_mag   <= set_data[CW-1:0];
      if (set_stb && (set_addr == 8'(BASE + 2))) r_phase <= set_data[CW-1:0];
    end
  end

  assign w_i_top = r_i2[OW-1 -: CW];

  // S3: products of I with both coefficients, data delayed alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm <= '0;
      r_pp <= '0;
      r_i3 <= '0;
      r_q3 <= '0;
    end else begin
      r_pm <= (2*CW)'(w_i_top) * (2*CW)'(r_mag);
      r_pp <= (2*CW)'(w_i_top) * (2*CW)'(r_phase);
      r_i3 <= r_i2;
      r_q3 <= r_q2;
    end
  end

  assign w_pm_sh  = r_pm >>> (CW - 1);
  assign w_pp_sh  = r_pp >>> (CW - 1);
  assign w_term_i = SW'(w_pm_sh) <<< (OW - CW);
  assign w_term_q = SW'(w_pp_sh) <<< (OW - CW);
  assign w_i_sum  = SW'(r_i3) + w_term_i;
  assign w_q_sum  = SW'(r_q3) + w_term_q;

  // S4: apply correction terms with saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      i_out <= '0;
      q_out <= '0;
    end else begin
      i_out <= sat_out(w_i_sum);
      q_out <= sat_out(w_q_sum);
    end
  end
`else
  // S3/S4: latency-matching delay without correction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i3  <= '0;
      r_q3  <= '0;
      i_out <= '0;
      q_out <= '0;
    end else begin
      r_i3  <= r_i2;
      r_q3  <= r_q2;
      i_out <= r_i3;
      q_out <= r_q3;
    end
  end
`endif

  logic [2:0] r_run_d;

  // Valid strobe: run delayed to match the data pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_d    <= '0;
      strobe_out <= 1'b0;
    end else begin
      r_run_d    <= {r_run_d[1:0], run};
      strobe_out <= r_run_d[2];
    end
  end

  // Saturating ADC overflow counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (w_wr_clr) begin
      ovf_count <= '0;
    end else if (run && (adc_ovf_a || adc_ovf_b) && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rx_frontend_iqcal.sv
// Scoreboard bench for rx_frontend_iqcal (DC_SHIFT=4, other parameters default).
module tb_rx_frontend_iqcal;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'h0;
  logic [31:0] set_data = 32'h0;
  logic [15:0] adc_a = 16'h0, adc_b = 16'h0;
  logic        adc_ovf_a = 1'b0, adc_ovf_b = 1'b0;
  logic        run = 1'b0;
  logic [23:0] i_out, q_out;
  logic        strobe_out;
  logic [15:0] ovf_count;

  rx_frontend_iqcal #(
    .BASE(0), .IN_WIDTH(16), .OUT_WIDTH(24), .CORR_WIDTH(18), .DC_SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .adc_a(adc_a), .adc_ovf_a(adc_ovf_a), .adc_b(adc_b), .adc_ovf_b(adc_ovf_b),
    .run(run), .i_out(i_out), .q_out(q_out), .strobe_out(strobe_out), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // mode 0: don't care, 1: exact I and Q, 2: |I| <= 16 and exact Q
  typedef struct {
    logic [23:0] i;
    logic [23:0] q;
    int          mode;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation for every strobed output
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (!rst && strobe_out) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got i=%h q=%h expected no output", i_out, q_out);
      end else begin
        e = sb_q.pop_front();
        if (e.mode == 1) begin
          check("i_out", 32'(i_out), 32'(e.i));
          check("q_out", 32'(q_out), 32'(e.q));
        end else if (e.mode == 2) begin
          v = int'($signed(i_out));
          n_tests++;
          if (v > 16 || v < -16) begin
            n_fail++;
            $display("FAIL dc_converge: got i=%0d expected |i|<=16", v);
          end
          check("dc_q", 32'(q_out), 32'(e.q));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r,
                       input logic oa, input logic ob, input int mode,
                       input logic [23:0] ei, input logic [23:0] eq);
    exp_t e;
    adc_a = a; adc_b = b; run = r; adc_ovf_a = oa; adc_ovf_b = ob;
    if (r) begin
      e.i = ei; e.q = eq; e.mode = mode;
      sb_q.push_back(e);
    end
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  task automatic vec(input logic [15:0] a, input logic [15:0] b,
                     input logic [23:0] ei, input logic [23:0] eq);
    drive(a, b, 1'b1, 1'b0, 1'b0, 1, ei, eq);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 24'h0, 24'h0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    idle(1);
  endtask

  initial begin
    logic [15:0] a;
    // Reset with run high: everything must clear
    rst = 1'b1; run = 1'b1; adc_a = 16'h1234; adc_b = 16'h4321; adc_ovf_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_i", 32'(i_out), 32'h0);
    check("rst_q", 32'(q_out), 32'h0);
    check("rst_strobe", 32'(strobe_out), 32'h0);
    check("rst_ovf", 32'(ovf_count), 32'h0);
    rst = 1'b0;

    // Plain pass-through, 4-cycle latency, strobe low for first 4 cycles
    for (int k = 0; k < 8; k++) begin
      if (k < 4) check("strobe_lo", 32'(strobe_out), 32'h0);
      a = 16'(32'h1000 + k);
      vec(a, 16'hF000, {a, 8'h00}, 24'hF00000);
    end
    idle(6);

    // Swap + invert Q, including most-negative inversion
    wr(8'd0, 32'h3);
    vec(16'h1000, 16'h8000, 24'h800000, 24'hF00000);
    vec(16'h8000, 16'h7FFF, 24'h7FFF00, 24'h7FFFFF);
    vec(16'h0001, 16'h0000, 24'h000000, 24'hFFFF00);
    idle(6);
    // Real-only mode
    wr(8'd0, 32'h4);
    vec(16'h1234, 16'h5678, 24'h123400, 24'h000000);
    idle(6);
    wr(8'd0, 32'h0);

    // Fixed DC offsets with saturation at both rails
    wr(8'd3, 32'h0FF00000);
    wr(8'd4, 32'h00100000);
    vec(16'h7FFF, 16'h0000, 24'h7FFFFF, 24'hF00000);
    vec(16'h7000, 16'h8000, 24'h7FFFFF, 24'h800000);
    vec(16'h6FFF, 16'h0100, 24'h7FFF00, 24'hF10000);
    vec(16'h8000, 16'h7FFF, 24'h900000, 24'h6FFF00);
    idle(6);
    wr(8'd3, 32'h0);
    wr(8'd4, 32'h0);

    // I/Q imbalance correction
    wr(8'd1, 32'h10000);
    wr(8'd2, 32'h08000);
`ifdef RX_IQCOMP_EN
    vec(16'h1000, 16'h0000, 24'h180000, 24'h040000);
    vec(16'hF000, 16'h0000, 24'hE80000, 24'hFC0000);
    vec(16'h0001, 16'h0000, 24'h000180, 24'h000040);
    vec(16'hFFFF, 16'h0000, 24'hFFFE80, 24'hFFFFC0);
`else
    vec(16'h1000, 16'h0000, 24'h100000, 24'h000000);
    vec(16'hF000, 16'h0000, 24'hF00000, 24'h000000);
    vec(16'h0001, 16'h0000, 24'h000100, 24'h000000);
    vec(16'hFFFF, 16'h0000, 24'hFFFF00, 24'h000000);
`endif
    idle(6);
    wr(8'd1, 32'h1FFFF);
`ifdef RX_IQCOMP_EN
    vec(16'h7FFF, 16'h0000, 24'h7FFFFF, 24'h1FFFC0);
`else
    vec(16'h7FFF, 16'h0000, 24'h7FFF00, 24'h000000);
`endif
    idle(6);
    wr(8'd1, 32'h0);
    wr(8'd2, 32'h0);

    // Auto DC tracking converges, then freezes with run low
    wr(8'd3, 32'h80000000);
    for (int k = 0; k < 2000; k++)
      drive(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, (k >= 1990) ? 2 : 0, 24'h0, 24'h0);
    for (int k = 0; k < 12; k++) begin
      drive(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 24'h0, 24'h0);
      if (k >= 5) check("dc_hold", 32'(i_out), 32'h010000);
    end
    wr(8'd3, 32'h0);
    idle(6);

    // Overflow counter: count, hold when run low, clear priority, saturation
    check("ovf_zero", 32'(ovf_count), 32'h0);
    repeat (5) drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1, 24'h0, 24'h0);
    drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1, 24'h0, 24'h0);
    check("ovf_5", 32'(ovf_count), 32'd5);
    repeat (2) drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1, 24'h0, 24'h0);
    check("ovf_b", 32'(ovf_count), 32'd7);
    repeat (3) drive(16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 0, 24'h0, 24'h0);
    check("ovf_norun", 32'(ovf_count), 32'd7);
    set_stb = 1'b1; set_addr = 8'd5; set_data = 32'h0;
    drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1, 24'h0, 24'h0);
    check("ovf_clr", 32'(ovf_count), 32'h0);
    repeat (70000) drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 0, 24'h0, 24'h0);
    check("ovf_sat", 32'(ovf_count), 32'hFFFF);
    repeat (3) drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 0, 24'h0, 24'h0);
    check("ovf_hold", 32'(ovf_count), 32'hFFFF);
    idle(8);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
